// File: rtl/hazard_ctrl.sv
// hazard_ctrl: issue/execute hazard, forwarding and mispredict-redirect controller with squash FSM.
module hazard_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [1:0]  WB_MEM       = 2'b01,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_is_i,
  input  logic [4:0]       rs1_is_i,
  input  logic [4:0]       rs2_is_i,
  input  logic             use_rs1_is_i,
  input  logic             use_rs2_is_i,
  input  logic             valid_ex_i,
  input  logic [4:0]       rd_ex_i,
  input  logic             rf_en_ex_i,
  input  logic [1:0]       wb_sel_ex_i,
  input  logic             is_b_type_ex_i,
  input  logic             jump_ex_i,
  input  logic             brn_taken_ex_i,
  input  logic [31:0]      next_brn_pc_ex_i,
  input  logic [31:0]      next_seq_pc_ex_i,
  input  logic [31:0]      next_pred_pc_ex_i,
  input  logic             valid_mem_i,
  input  logic             rf_en_mem_i,
  input  logic [4:0]       rd_mem_i,
  input  logic             valid_wb_i,
  input  logic             rf_en_wb_i,
  input  logic [4:0]       rd_wb_i,
  output logic             stall_if_o,
  output logic             stall_is_o,
  output logic             clr_ex_o,
  output logic             flush_is_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [1:0]       fwd_sel_p1_o,
  output logic [1:0]       fwd_sel_p2_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic wr_ex, wr_mem, wr_wb, taken, mispredict, load_use;
  logic [31:0] actual_pc;
  assign wr_ex  = valid_ex_i & rf_en_ex_i & |rd_ex_i;
  assign wr_mem = valid_mem_i & rf_en_mem_i & |rd_mem_i;
  assign wr_wb  = valid_wb_i & rf_en_wb_i & |rd_wb_i;
  assign fwd_sel_p1_o = !use_rs1_is_i ? 2'd0 :
                        (wr_ex  && rd_ex_i  == rs1_is_i) ? 2'd1 :
                        (wr_mem && rd_mem_i == rs1_is_i) ? 2'd2 :
                        (wr_wb  && rd_wb_i  == rs1_is_i) ? 2'd3 : 2'd0;
  assign fwd_sel_p2_o = !use_rs2_is_i ? 2'd0 :
                        (wr_ex  && rd_ex_i  == rs2_is_i) ? 2'd1 :
                        (wr_mem && rd_mem_i == rs2_is_i) ? 2'd2 :
                        (wr_wb  && rd_wb_i  == rs2_is_i) ? 2'd3 : 2'd0;
  assign taken      = jump_ex_i | (is_b_type_ex_i & brn_taken_ex_i);
  assign actual_pc  = taken ? next_brn_pc_ex_i : next_seq_pc_ex_i;
  assign mispredict = valid_ex_i & (is_b_type_ex_i | jump_ex_i) & (actual_pc != next_pred_pc_ex_i);
  assign load_use   = wr_ex & (wb_sel_ex_i == WB_MEM) & valid_is_i &
                      ((use_rs1_is_i & rs1_is_i == rd_ex_i) | (use_rs2_is_i & rs2_is_i == rd_ex_i));
  assign busy_o = state_q == FLUSH;
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    stall_if_o       = 1'b0;
    stall_is_o       = 1'b0;
    clr_ex_o         = 1'b0;
    flush_is_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    if (state_q == FLUSH) begin
      clr_ex_o    = 1'b1;
      flush_is_o  = 1'b1;
      state_d     = flush_cnt_q == 3'd0 ? RUN : FLUSH;
      flush_cnt_d = flush_cnt_q == 3'd0 ? 3'd0 : flush_cnt_q - 3'd1;
    end else if (mispredict) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = actual_pc;
      clr_ex_o         = 1'b1;
      flush_is_o       = 1'b1;
      state_d          = FLUSH_CYCLES > 0 ? FLUSH : RUN;
      flush_cnt_d      = FLUSH_CYCLES > 0 ? FLUSH_INIT : 3'd0;
    end else if (load_use) begin
      stall_if_o = 1'b1;
      stall_is_o = 1'b1;
      clr_ex_o   = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (stall_if_o && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect_valid_o && !(&flush_cnt_o))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
endmodule
